// File: rtl/fpu_pkg.sv
// Shared F-extension definitions: FSM encodings, rounding modes and format constants.
package fpu_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned EXP_W    = 8;
   localparam int unsigned BIAS     = 127;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ABS   = 3'd1;
   localparam logic [2:0] ST_NORM  = 3'd2;
   localparam logic [2:0] ST_ROUND = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ABS   = ST_ABS,
      S_NORM  = ST_NORM,
      S_ROUND = ST_ROUND,
      S_DONE  = ST_DONE
   } state_e;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision from sign, lsb, guard and sticky; unknown modes round to nearest-even.
module fp_round_inc
   import fpu_pkg::*;
(
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   input  logic [2:0] rm,
   output logic       inc
);

   always_comb begin
      inc = 1'b0;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | lsb);
      endcase
   end

endmodule

// File: rtl/int_to_fp_converter.sv
// FCVT.S.W / FCVT.S.WU: iterative integer-to-binary32 conversion, one normalisation bit per cycle.
module int_to_fp_converter
   import fpu_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned EXP_INIT = 158
) (
   input  logic            CLK,
   input  logic            RST_n,
   input  logic            START,
   input  logic [XLEN-1:0] OP_A,
   input  logic            IS_UNSIGNED,
   input  logic [2:0]      RM,
   output logic [31:0]     R,
   output logic            BUSY,
   output logic            DONE,
   output logic            NX
);

   state_e                state_q, state_n;
   logic [XLEN-1:0]       op_q, op_n;
   logic [XLEN-1:0]       mag_q, mag_n;
   logic                  uns_q, uns_n;
   logic                  sign_q, sign_n;
   logic [2:0]            rm_q, rm_n;
   logic [EXP_W-1:0]      exp_q, exp_n;
   logic [31:0]           r_n;
   logic                  nx_n;

   logic                  abs_sign;
   logic [XLEN-1:0]       abs_mag;
   logic [FRAC_W-1:0]     frac;
   logic                  guard, sticky, inc;
   logic [FRAC_W:0]       frac_sum;
   logic [EXP_W-1:0]      exp_rnd;

   // Magnitude of the latched operand; 0x80000000 signed maps onto itself as unsigned.
   assign abs_sign = ~uns_q & op_q[XLEN-1];
   assign abs_mag  = abs_sign ? (~op_q + XLEN'(1)) : op_q;

   // Normalised mantissa fields: hidden bit at mag[XLEN-1].
   assign frac     = mag_q[XLEN-2 -: FRAC_W];
   assign guard    = mag_q[XLEN-2-FRAC_W];
   assign sticky   = |mag_q[XLEN-3-FRAC_W:0];
   assign frac_sum = {1'b0, frac} + (FRAC_W+1)'(inc);
   assign exp_rnd  = frac_sum[FRAC_W] ? (exp_q + EXP_W'(1)) : exp_q;

   fp_round_inc u_round_inc (
      .sign   (sign_q),
      .lsb    (frac[0]),
      .guard  (guard),
      .sticky (sticky),
      .rm     (rm_q),
      .inc    (inc)
   );

   always_comb begin
      state_n = state_q;
      op_n    = op_q;
      uns_n   = uns_q;
      rm_n    = rm_q;
      sign_n  = sign_q;
      mag_n   = mag_q;
      exp_n   = exp_q;
      r_n     = R;
      nx_n    = NX;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               op_n    = OP_A;
               uns_n   = IS_UNSIGNED;
               rm_n    = RM;
               state_n = S_ABS;
            end
         end
         S_ABS: begin
            sign_n = abs_sign;
            mag_n  = abs_mag;
            exp_n  = EXP_W'(EXP_INIT);
            if (abs_mag == '0) begin
               r_n     = '0;
               nx_n    = 1'b0;
               state_n = S_DONE;
            end else begin
               state_n = S_NORM;
            end
         end
         S_NORM: begin
            if (mag_q[XLEN-1]) begin
               state_n = S_ROUND;
            end else begin
               mag_n = mag_q << 1;
               exp_n = exp_q - EXP_W'(1);
            end
         end
         S_ROUND: begin
            // Fraction carry-out lands in frac_sum's top bit; the stored fraction is then zero.
            r_n     = {sign_q, exp_rnd, frac_sum[FRAC_W-1:0]};
            nx_n    = guard | sticky;
            state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         uns_q   <= 1'b0;
         rm_q    <= '0;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         exp_q   <= '0;
         R       <= '0;
         NX      <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state_q <= state_n;
         op_q    <= op_n;
         uns_q   <= uns_n;
         rm_q    <= rm_n;
         sign_q  <= sign_n;
         mag_q   <= mag_n;
         exp_q   <= exp_n;
         R       <= r_n;
         NX      <= nx_n;
         BUSY    <= (state_n != S_IDLE);
         DONE    <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed and random checks of int_to_fp_converter against an expected-result queue.
module tb_int_to_fp_converter;
   import fpu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        START;
   logic [31:0] OP_A;
   logic        IS_UNSIGNED;
   logic [2:0]  RM;
   logic [31:0] R;
   logic        BUSY;
   logic        DONE;
   logic        NX;

   typedef struct {
      logic [31:0] r;
      logic        nx;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_r = '0;

   always #5 CLK = ~CLK;

   int_to_fp_converter dut (
      .CLK         (CLK),
      .RST_n       (RST_n),
      .START       (START),
      .OP_A        (OP_A),
      .IS_UNSIGNED (IS_UNSIGNED),
      .RM          (RM),
      .R           (R),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .NX          (NX)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference conversion by exact shift-and-compare rounding, plus expected latency.
   function automatic exp_t model(input logic [31:0] a, input logic uns, input logic [2:0] rm);
      exp_t        e;
      logic        s;
      logic [31:0] m, keep, rem, half;
      logic        up;
      int          p;
      s = !uns && a[31];
      m = s ? -a : a;
      if (m == 32'd0) begin
         e.r = '0; e.nx = 1'b0; e.lat = 2;
         return e;
      end
      p = 31;
      while (!m[p]) p--;
      e.lat = 4 + (31 - p);
      if (p <= 23) begin
         keep = m << (23 - p);
         e.nx = 1'b0;
      end else begin
         keep = m >> (p - 23);
         rem  = m & ((32'd1 << (p - 23)) - 32'd1);
         half = 32'd1 << (p - 24);
         e.nx = (rem != 32'd0);
         case (rm)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = s && (rem != 32'd0);
            RM_RUP:  up = !s && (rem != 32'd0);
            RM_RMM:  up = (rem >= half);
            default: up = (rem > half) || ((rem == half) && keep[0]);
         endcase
         if (up) keep = keep + 32'd1;
         if (keep[24]) begin
            keep = keep >> 1;
            p++;
         end
      end
      e.r = {s, 8'(127 + p), keep[22:0]};
      return e;
   endfunction

   // One conversion; poke raises START during ABS and during the DONE cycle, both must be ignored.
   task automatic run(input logic [31:0] a, input logic uns, input logic [2:0] rm,
                      input logic [31:0] er, input logic enx, input int elat, input bit poke);
      exp_t e, got;
      int   n;
      bit   seen;
      e.r = er; e.nx = enx; e.lat = elat;
      sb.push_back(e);
      @(negedge CLK);
      OP_A = a; IS_UNSIGNED = uns; RM = rm; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      n = 1;
      check("busy_rise", 32'(BUSY), 32'd1);
      check("r_hold", R, last_r);
      if (poke) begin
         OP_A = ~a; START = 1'b1;
      end
      seen = 1'b0;
      while (!seen && n < 60) begin
         if (DONE) begin
            seen = 1'b1;
         end else begin
            @(negedge CLK);
            START = 1'b0;
            n++;
         end
      end
      if (!seen) begin
         check("done_timeout", 32'(n), 32'(elat));
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      got = sb.pop_front();
      check("result", R, got.r);
      check("nx", 32'(NX), 32'(got.nx));
      check("latency", 32'(n), 32'(got.lat));
      last_r = got.r;
      if (poke) START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("done_pulse", 32'(DONE), 32'd0);
      check("busy_fall", 32'(BUSY), 32'd0);
      if (poke) begin
         repeat (3) begin
            @(negedge CLK);
            check("ignored_start_busy", 32'(BUSY), 32'd0);
         end
         check("ignored_start_r", R, last_r);
      end
   endtask

   initial begin
      exp_t m;
      int   dn;
      logic [31:0] a;
      logic        u;
      logic [2:0]  rm;

      RST_n = 1'b0; START = 1'b0; OP_A = '0; IS_UNSIGNED = 1'b0; RM = RM_RNE;
      repeat (3) @(negedge CLK);
      check("reset_r", R, 32'd0);
      check("reset_busy", 32'(BUSY), 32'd0);
      check("reset_done", 32'(DONE), 32'd0);
      check("reset_nx", 32'(NX), 32'd0);
      RST_n = 1'b1;

      run(32'h0000_0001, 1'b0, RM_RNE, 32'h3F80_0000, 1'b0, 35, 1'b0);
      run(32'hFFFF_FFFF, 1'b0, RM_RNE, 32'hBF80_0000, 1'b0, 35, 1'b0);
      run(32'hFFFF_FFFF, 1'b1, RM_RNE, 32'h4F80_0000, 1'b1, 4,  1'b0);
      run(32'hFFFF_FFFF, 1'b1, RM_RTZ, 32'h4F7F_FFFF, 1'b1, 4,  1'b0);
      run(32'h8000_0000, 1'b0, RM_RNE, 32'hCF00_0000, 1'b0, 4,  1'b0);
      run(32'h8000_0000, 1'b1, RM_RNE, 32'h4F00_0000, 1'b0, 4,  1'b0);
      run(32'h0100_0001, 1'b1, RM_RNE, 32'h4B80_0000, 1'b1, 11, 1'b0);
      run(32'h0100_0001, 1'b1, RM_RUP, 32'h4B80_0001, 1'b1, 11, 1'b0);
      run(32'hFEFF_FFFF, 1'b0, RM_RDN, 32'hCB80_0001, 1'b1, 11, 1'b0);
      run(32'h0100_0001, 1'b1, RM_RMM, 32'h4B80_0001, 1'b1, 11, 1'b0);
      run(32'h0100_0001, 1'b1, 3'b101, 32'h4B80_0000, 1'b1, 11, 1'b0);
      run(32'h0000_0000, 1'b0, RM_RNE, 32'h0000_0000, 1'b0, 2,  1'b0);
      run(32'h00AB_CDEF, 1'b1, RM_RNE, 32'h4B2B_CDEF, 1'b0, 12, 1'b1);

      // Abort a conversion in NORM with reset.
      @(negedge CLK);
      OP_A = 32'h0000_0001; IS_UNSIGNED = 1'b0; RM = RM_RNE; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (9) @(negedge CLK);
      RST_n = 1'b0;
      #1;
      check("abort_busy", 32'(BUSY), 32'd0);
      check("abort_r", R, 32'd0);
      check("abort_done", 32'(DONE), 32'd0);
      last_r = '0;
      dn = 0;
      repeat (2) @(negedge CLK);
      RST_n = 1'b1;
      repeat (40) begin
         @(negedge CLK);
         if (DONE) dn++;
      end
      check("abort_no_done", 32'(dn), 32'd0);
      run(32'h0000_0005, 1'b0, RM_RNE, 32'h40A0_0000, 1'b0, 33, 1'b0);

      repeat (24) begin
         a  = $urandom >> $urandom_range(0, 31);
         u  = 1'($urandom_range(0, 1));
         rm = 3'($urandom_range(0, 6));
         if (!u && $urandom_range(0, 1) == 1) a = -a;
         m = model(a, u, rm);
         run(a, u, rm, m.r, m.nx, m.lat, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
